// File: rtl/shift_seq_ctrl.sv
// Sequencer that turns one multi-bit logical shift request into a series of
// single-bit operations on an external registered shift unit.
module shift_seq_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int AMT_WIDTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic [DATA_WIDTH-1:0] REQ_DATA,
    input  logic                  REQ_DIR,
    input  logic [AMT_WIDTH-1:0]  REQ_AMT,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [DATA_WIDTH-1:0] RSP_DATA,
    output logic                  RSP_ERR,
    output logic [DATA_WIDTH-1:0] SU_A,
    output logic [DATA_WIDTH-1:0] SU_B,
    output logic [1:0]            SU_FUNC,
    output logic                  SU_EN,
    input  logic [DATA_WIDTH-1:0] SU_OUT,
    input  logic                  SU_FLAG
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_work;
    logic [DATA_WIDTH-1:0] w_work_nxt;
    logic [AMT_WIDTH-1:0]  r_cnt;
    logic [AMT_WIDTH-1:0]  w_cnt_nxt;
    logic                  r_dir;
    logic                  w_dir_nxt;
    logic                  r_err;
    logic                  w_err_nxt;
    logic                  w_cnt_last;

    // A count of one (or the unreachable zero) means this acknowledge is the final step.
    assign w_cnt_last = (r_cnt <= AMT_WIDTH'(1));

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_work  <= {DATA_WIDTH{1'b0}};
            r_cnt   <= {AMT_WIDTH{1'b0}};
            r_dir   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (REQ_VALID) begin
                    w_work_nxt  = REQ_DATA;
                    w_cnt_nxt   = REQ_AMT;
                    w_dir_nxt   = REQ_DIR;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = (REQ_AMT == {AMT_WIDTH{1'b0}}) ? S_DONE : S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (SU_FLAG) begin
                    w_work_nxt  = SU_OUT;
                    // Saturating decrement keeps the counter from wrapping.
                    if (r_cnt != {AMT_WIDTH{1'b0}}) begin
                        w_cnt_nxt = r_cnt - AMT_WIDTH'(1);
                    end else begin
                        w_cnt_nxt = r_cnt;
                    end
                    w_state_nxt = w_cnt_last ? S_DONE : S_ISSUE;
                end else begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (RSP_READY) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Moore output decode from state and registers only.
    always_comb begin
        REQ_READY = 1'b0;
        RSP_VALID = 1'b0;
        RSP_DATA  = {DATA_WIDTH{1'b0}};
        RSP_ERR   = 1'b0;
        SU_EN     = 1'b0;
        SU_A      = {DATA_WIDTH{1'b0}};
        SU_FUNC   = 2'b00;
        case (r_state)
            S_IDLE: begin
                REQ_READY = 1'b1;
            end
            S_ISSUE: begin
                SU_EN   = 1'b1;
                SU_A    = r_work;
                SU_FUNC = r_dir ? 2'b01 : 2'b00;
            end
            S_WAIT: begin
                SU_EN = 1'b0;
            end
            S_DONE: begin
                RSP_VALID = 1'b1;
                RSP_DATA  = r_work;
                RSP_ERR   = r_err;
            end
            default: begin
                REQ_READY = 1'b0;
            end
        endcase
    end

    assign SU_B = {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed cases plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_shift_seq_ctrl;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ_VALID;
    logic          REQ_READY;
    logic [DW-1:0] REQ_DATA;
    logic          REQ_DIR;
    logic [AW-1:0] REQ_AMT;
    logic          RSP_VALID;
    logic          RSP_READY;
    logic [DW-1:0] RSP_DATA;
    logic          RSP_ERR;
    logic [DW-1:0] SU_A;
    logic [DW-1:0] SU_B;
    logic [1:0]    SU_FUNC;
    logic          SU_EN;
    logic [DW-1:0] SU_OUT;
    logic          SU_FLAG;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  chk_en  = 1'b0;
    bit  stuck   = 1'b0;

    shift_seq_ctrl #(.DATA_WIDTH(DW), .AMT_WIDTH(AW)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_DATA(REQ_DATA),
        .REQ_DIR(REQ_DIR), .REQ_AMT(REQ_AMT),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
        .SU_A(SU_A), .SU_B(SU_B), .SU_FUNC(SU_FUNC), .SU_EN(SU_EN),
        .SU_OUT(SU_OUT), .SU_FLAG(SU_FLAG)
    );

    initial forever #5 CLK = ~CLK;

    // Registered single-bit shift unit; 'stuck' suppresses its acknowledge.
    always @(posedge CLK) begin
        SU_FLAG <= SU_EN && !stuck;
        SU_OUT  <= SU_FUNC[0] ? (SU_A << 1) : (SU_A >> 1);
    end

    function automatic logic [DW-1:0] shv(input logic [DW-1:0] d, input bit dir, input int n);
        return dir ? (d << n) : (d >> n);
    endfunction

    task automatic bump(input string name, input bit bad, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic check1(input string name, input logic act, input logic exp);
        bump(name, act !== exp, {31'd0, act}, {31'd0, exp});
    endtask
    task automatic check16(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        bump(name, act !== exp, {16'd0, act}, {16'd0, exp});
    endtask
    task automatic checki(input string name, input int act, input int exp);
        bump(name, act != exp, act, exp);
    endtask

    // Transaction model: one operation at a time, result and completion cycle
    // computed directly from the request.
    int            cyc = 0;
    bit            m_busy = 1'b0;
    int            m_e = 0;
    int            m_done = 0;
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] m_res = '0;
    bit            m_dir = 1'b0;
    bit            m_err = 1'b0;
    int            m_amt = 0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_busy = 1'b0;
        end else begin
            if (m_busy && cyc >= m_done && RSP_READY) begin
                m_busy = 1'b0;
            end else if (!m_busy && REQ_VALID) begin
                m_busy = 1'b1;
                m_e    = cyc + 1;
                m_data = REQ_DATA;
                m_dir  = REQ_DIR;
                m_amt  = int'(REQ_AMT);
                if (m_amt == 0) begin
                    m_res = REQ_DATA; m_err = 1'b0; m_done = m_e;
                end else if (stuck) begin
                    m_res = REQ_DATA; m_err = 1'b1; m_done = m_e + 2;
                end else begin
                    m_res = shv(REQ_DATA, REQ_DIR, m_amt); m_err = 1'b0; m_done = m_e + 2 * m_amt;
                end
            end
            cyc = cyc + 1;
        end
    end

    bit            e_valid;
    bit            e_issue;
    logic [DW-1:0] e_a;

    // Per-cycle comparison of every output against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            e_valid = m_busy && (cyc >= m_done);
            e_issue = m_busy && (cyc < m_done) && (((cyc - m_e) % 2) == 0);
            e_a     = e_issue ? shv(m_data, m_dir, (cyc - m_e) / 2) : 16'h0000;
            check1 ("c_req_ready", REQ_READY, !m_busy);
            check1 ("c_rsp_valid", RSP_VALID, e_valid);
            check16("c_rsp_data",  RSP_DATA,  e_valid ? m_res : 16'h0000);
            check1 ("c_rsp_err",   RSP_ERR,   e_valid ? m_err : 1'b0);
            check1 ("c_su_en",     SU_EN,     e_issue);
            check16("c_su_a",      SU_A,      e_a);
            check16("c_su_b",      SU_B,      16'h0000);
            check1 ("c_su_func0",  SU_FUNC[0], e_issue ? m_dir : 1'b0);
            check1 ("c_su_func1",  SU_FUNC[1], 1'b0);
        end
    end

    task automatic run_op(input logic [DW-1:0] d, input bit dir, input int amt, input bit stk,
                          input int hold, input logic [DW-1:0] exp_d, input bit exp_e,
                          input int exp_lat, input int exp_en, input string tag);
        int lat;
        int en_cnt;
        check1({tag, "_accept_ready"}, REQ_READY, 1'b1);
        stuck = stk; REQ_DATA = d; REQ_DIR = dir; REQ_AMT = AW'(amt);
        REQ_VALID = 1'b1; RSP_READY = 1'b0;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0; REQ_DATA = 16'($urandom); REQ_AMT = 4'($urandom);
        lat = 1;
        en_cnt = int'(SU_EN);
        while (!RSP_VALID && lat < 200) begin
            @(posedge CLK); #1;
            lat++;
            en_cnt += int'(SU_EN);
        end
        checki ({tag, "_latency"}, lat, exp_lat);
        checki ({tag, "_su_en_pulses"}, en_cnt, exp_en);
        check16({tag, "_data"}, RSP_DATA, exp_d);
        check1 ({tag, "_err"}, RSP_ERR, exp_e);
        for (int i = 0; i < hold; i++) begin
            @(posedge CLK); #1;
            check1 ({tag, "_hold_valid"}, RSP_VALID, 1'b1);
            check16({tag, "_hold_data"}, RSP_DATA, exp_d);
            check1 ({tag, "_hold_ready"}, REQ_READY, 1'b0);
        end
        RSP_READY = 1'b1;
        @(posedge CLK); #1;
        RSP_READY = 1'b0;
        check1({tag, "_idle_after"}, REQ_READY, 1'b1);
        check1({tag, "_valid_after"}, RSP_VALID, 1'b0);
        stuck = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout global bound reached");
        $fatal(1, "timeout");
    end

    initial begin
        int wait_cyc;
        RST = 1'b1; REQ_VALID = 1'b0; RSP_READY = 1'b0;
        REQ_DATA = 16'h0000; REQ_DIR = 1'b0; REQ_AMT = 4'd0;
        repeat (2) @(posedge CLK);
        #1;
        check1 ("rst_req_ready", REQ_READY, 1'b1);
        check1 ("rst_rsp_valid", RSP_VALID, 1'b0);
        check16("rst_rsp_data",  RSP_DATA, 16'h0000);
        check1 ("rst_su_en",     SU_EN, 1'b0);
        check16("rst_su_a",      SU_A, 16'h0000);
        RST = 1'b0;
        chk_en = 1'b1;

        check16("model_pin_left", shv(16'h0001, 1'b1, 3), 16'h0008);
        check16("model_pin_right", shv(16'h8000, 1'b0, 15), 16'h0001);

        run_op(16'h0001, 1'b1, 3,  1'b0, 0, 16'h0008, 1'b0, 7,  3,  "left3");
        run_op(16'h8000, 1'b0, 15, 1'b0, 0, 16'h0001, 1'b0, 31, 15, "right15");
        run_op(16'hA5A5, 1'b0, 0,  1'b0, 0, 16'hA5A5, 1'b0, 1,  0,  "amt0");
        run_op(16'h000F, 1'b1, 4,  1'b0, 5, 16'h00F0, 1'b0, 9,  4,  "stall");
        run_op(16'h1234, 1'b0, 2,  1'b1, 0, 16'h1234, 1'b1, 3,  1,  "stuck");
        run_op(16'hFFFF, 1'b1, 15, 1'b0, 0, 16'h8000, 1'b0, 31, 15, "left15");

        // Reset during the second WAIT of a four-step left shift.
        REQ_DATA = 16'h0003; REQ_DIR = 1'b1; REQ_AMT = 4'd4; REQ_VALID = 1'b1;
        @(posedge CLK); #1;
        REQ_VALID = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        check1("rst_mid_busy", REQ_READY, 1'b0);
        #2 RST = 1'b1;
        #1;
        check1 ("rst_mid_req_ready", REQ_READY, 1'b1);
        check1 ("rst_mid_rsp_valid", RSP_VALID, 1'b0);
        check16("rst_mid_rsp_data",  RSP_DATA, 16'h0000);
        check1 ("rst_mid_rsp_err",   RSP_ERR, 1'b0);
        check1 ("rst_mid_su_en",     SU_EN, 1'b0);
        check16("rst_mid_su_a",      SU_A, 16'h0000);
        check1 ("rst_mid_su_func",   SU_FUNC[0], 1'b0);
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (4) begin
            @(posedge CLK); #1;
            check1("rst_no_rsp", RSP_VALID, 1'b0);
        end
        run_op(16'h0C00, 1'b0, 3, 1'b0, 0, 16'h0180, 1'b0, 7, 3, "post_rst");

        // Randomized traffic, including requests presented while busy.
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            REQ_VALID = ($urandom_range(0, 2) != 0);
            REQ_DATA  = 16'($urandom);
            REQ_DIR   = 1'($urandom);
            REQ_AMT   = 4'($urandom);
            if ($urandom_range(0, 5) == 0) REQ_AMT = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'd15;
            RSP_READY = ($urandom_range(0, 3) != 0);
            if (!m_busy) stuck = ($urandom_range(0, 15) == 0);
        end
        @(negedge CLK);
        REQ_VALID = 1'b0; RSP_READY = 1'b1;
        wait_cyc = 0;
        while (m_busy && wait_cyc < 100) begin
            @(negedge CLK);
            wait_cyc++;
        end
        check1("drain_idle", m_busy, 1'b0);
        @(negedge CLK);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
